// File: rtl/poro_pkg.sv
// Shared encodings and widths for the Poro Round-Up game-level controller.
package poro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } game_state_t;

    localparam int SCREEN_X_MAX = 319;
    localparam int BLITZ_X      = 43;
    localparam int SCORE_W      = 10;
    localparam int LIVES_W      = 3;
    localparam int CNT_W        = 6;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/poro_rr_arb.sv
// N-way round-robin arbiter: grant is the first requester at or after the pointer;
// on advance the pointer moves one past the winner.
module poro_rr_arb #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (int'(win) == N - 1) ? '0 : win + PW'(1);
        end
    end

endmodule

// File: rtl/poro_wave_ctrl.sv
// Game-level scheduler: staggered lane release, shared round-robin hook, score and lives.
// Build option PORO_SPEEDUP_EN: spawn gap shrinks with score and dying lanes are re-held.
//
// state   | meaning
// ST_IDLE | power-up; all lanes parked, waiting for start
// ST_PLAY | game running: spawning, hook arbitration, scoring
// ST_OVER | lives exhausted; lanes parked, score/lives frozen until start
module poro_wave_ctrl
    import poro_pkg::*;
#(
    parameter int                 N_LANES     = 4,
    parameter logic [CNT_W-1:0]   SPAWN_GAP   = 6'd40,
    parameter logic [CNT_W-1:0]   HOOK_FRAMES = 6'd20,
    parameter logic [LIVES_W-1:0] START_LIVES = 3'd3,
    parameter logic [SCORE_W-1:0] SCORE_MAX   = 10'd999
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame,
    input  logic                start,
    input  logic                hook_fire,
    input  logic [N_LANES-1:0]  hook_req,
    input  logic [N_LANES-1:0]  lane_score,
    input  logic [N_LANES-1:0]  lane_dead,
    output logic [N_LANES-1:0]  lane_hold,
    output logic [N_LANES-1:0]  lane_grab,
    output logic                hook_busy,
    output logic [SCORE_W-1:0]  score,
    output logic [LIVES_W-1:0]  lives,
    output logic [1:0]          state
);
    localparam int IW = $clog2(N_LANES + 1);

    game_state_t        st, st_nxt;
    logic [N_LANES-1:0] score_q, dead_q, dead_rise, catch_v, elig, grant;
    logic [3:0]         n_catch, n_dead;
    logic [SCORE_W:0]   score_sum;
    logic               fire_ok, all_out;
    logic [CNT_W-1:0]   hook_cnt, spawn_cnt, gap;
    logic [IW-1:0]      spawn_idx;

    assign state     = st;
    assign dead_rise = lane_dead & ~dead_q;
    assign catch_v   = score_q & ~lane_score & ~dead_rise;
    assign elig      = hook_req & ~lane_hold;
    assign n_catch   = popcount8(8'(catch_v));
    assign n_dead    = popcount8(8'(dead_rise));
    assign score_sum = {1'b0, score} + {{(SCORE_W - 3){1'b0}}, n_catch};
    assign all_out   = (spawn_idx == IW'(N_LANES));
    // Only accept a fire that will still be in PLAY when the grab pulse appears.
    assign fire_ok   = (st == ST_PLAY) && (st_nxt == ST_PLAY) && hook_fire && !hook_busy;

`ifdef PORO_SPEEDUP_EN
    logic [SCORE_W-1:0] gap_cut;
    assign gap_cut = {1'b0, score[SCORE_W-1:3], 2'b00};
    assign gap = (gap_cut + SCORE_W'(8) >= SCORE_W'(SPAWN_GAP)) ? CNT_W'(8)
               : SPAWN_GAP - gap_cut[CNT_W-1:0];
`else
    assign gap = SPAWN_GAP;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) st <= ST_IDLE;
        else       st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE, ST_OVER: if (start) st_nxt = ST_PLAY;
            ST_PLAY:          if (lives == '0) st_nxt = ST_OVER;
            default:          st_nxt = ST_IDLE;
        endcase
    end

    poro_rr_arb #(.N(N_LANES)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (elig),
        .advance (fire_ok),
        .grant   (grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_grab <= '0;
            hook_busy <= 1'b0;
            hook_cnt  <= '0;
        end else begin
            lane_grab <= fire_ok ? grant : '0;
            if (st != ST_PLAY || st_nxt != ST_PLAY) begin
                hook_busy <= 1'b0;
                hook_cnt  <= '0;
            end else if (fire_ok) begin
                hook_busy <= 1'b1;
                hook_cnt  <= HOOK_FRAMES;
            end else if (hook_busy && frame) begin
                hook_cnt <= hook_cnt - CNT_W'(1);
                if (hook_cnt == CNT_W'(1)) hook_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score   <= '0;
            lives   <= START_LIVES;
            score_q <= '0;
            dead_q  <= '0;
        end else begin
            score_q <= lane_score;
            dead_q  <= lane_dead;
            if (st != ST_PLAY) begin
                if (start) begin
                    score <= '0;
                    lives <= START_LIVES;
                end
            end else begin
                score <= (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[SCORE_W-1:0];
                lives <= ({1'b0, lives} <= n_dead) ? '0 : lives - n_dead[LIVES_W-1:0];
            end
        end
    end

`ifdef PORO_SPEEDUP_EN
    logic [CNT_W-1:0] rs_cnt [N_LANES];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_hold <= '1;
            spawn_idx <= '0;
            spawn_cnt <= '0;
`ifdef PORO_SPEEDUP_EN
            for (int i = 0; i < N_LANES; i++) rs_cnt[i] <= '0;
`endif
        end else if (st_nxt != ST_PLAY) begin
            lane_hold <= '1;
            spawn_idx <= '0;
            spawn_cnt <= '0;
        end else if (st == ST_PLAY) begin
            if (frame && !all_out) begin
                if (spawn_cnt == '0) begin
                    for (int i = 0; i < N_LANES; i++) begin
                        if (spawn_idx == IW'(i)) lane_hold[i] <= 1'b0;
                    end
                    spawn_idx <= spawn_idx + IW'(1);
                    spawn_cnt <= gap - CNT_W'(1);
                end else begin
                    spawn_cnt <= spawn_cnt - CNT_W'(1);
                end
            end
`ifdef PORO_SPEEDUP_EN
            // Once the wave is fully out, a dying lane sits out one effective gap.
            if (all_out) begin
                for (int i = 0; i < N_LANES; i++) begin
                    if (dead_rise[i]) begin
                        lane_hold[i] <= 1'b1;
                        rs_cnt[i]    <= gap - CNT_W'(1);
                    end else if (frame && lane_hold[i]) begin
                        if (rs_cnt[i] == '0) lane_hold[i] <= 1'b0;
                        else                 rs_cnt[i] <= rs_cnt[i] - CNT_W'(1);
                    end
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_poro_wave_ctrl.sv
// Directed-plus-random bench for poro_wave_ctrl against a frame/score/lives reference model.
module tb_poro_wave_ctrl;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset, frame, start, hook_fire;
    logic [N-1:0] hook_req, lane_score, lane_dead, lane_hold, lane_grab;
    logic         hook_busy;
    logic [9:0]   score;
    logic [2:0]   lives;
    logic [1:0]   state;

    int errors = 0;
    int checks = 0;
    int score_m, lives_m, ptr_m, frames_m;
    bit play_m;

    poro_wave_ctrl #(.N_LANES(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame      (frame),
        .start      (start),
        .hook_fire  (hook_fire),
        .hook_req   (hook_req),
        .lane_score (lane_score),
        .lane_dead  (lane_dead),
        .lane_hold  (lane_hold),
        .lane_grab  (lane_grab),
        .hook_busy  (hook_busy),
        .score      (score),
        .lives      (lives),
        .state      (state)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_frame();
        frame = 1'b1;
        cyc();
        frame = 1'b0;
        cyc();
        cyc();
        cyc();
        frames_m++;
    endtask

    // Lane k is out from frame 1 + 40*k of the current game.
    function automatic logic [3:0] hold_model(input int f);
        logic [3:0] h;
        h = 4'hF;
        for (int k = 0; k < N; k++) if (f >= 1 + 40 * k) h[k] = 1'b0;
        return h;
    endfunction

    function automatic int rr_pick(input logic [3:0] req, input int ptr);
        for (int d = 0; d < N; d++) if (req[(ptr + d) % N]) return (ptr + d) % N;
        return -1;
    endfunction

    task automatic fire_and_check(input logic [3:0] req, input logic [3:0] holdv);
        int win;
        logic [3:0] e;
        win = rr_pick(req & ~holdv, ptr_m);
        e = (win < 0) ? 4'd0 : 4'(1 << win);
        hook_req  = req;
        hook_fire = 1'b1;
        cyc();
        hook_fire = 1'b0;
        chk("grab", 32'(lane_grab), 32'(e));
        chk("busy_set", 32'(hook_busy), 32'd1);
        if (win >= 0) ptr_m = (win + 1) % N;
        cyc();
        chk("grab_one_clk", 32'(lane_grab), 32'd0);
    endtask

    task automatic cooldown(input bit poke);
        for (int f = 1; f <= 20; f++) begin
            if (poke && f == 5) begin
                hook_req  = 4'hF;
                hook_fire = 1'b1;
                cyc();
                hook_fire = 1'b0;
                chk("fire_while_busy", 32'(lane_grab), 32'd0);
            end
            do_frame();
            chk("busy_cooldown", 32'(hook_busy), (f < 20) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic catch_lanes(input logic [3:0] m);
        lane_score = m;
        cyc();
        lane_score = '0;
        cyc();
        if (play_m) score_m = (score_m + $countones(m) > 999) ? 999 : score_m + $countones(m);
        chk("score", 32'(score), 32'(score_m));
    endtask

    initial begin
        logic [3:0] m;
        reset = 1'b1; frame = 1'b0; start = 1'b0; hook_fire = 1'b0;
        hook_req = '0; lane_score = '0; lane_dead = '0;
        score_m = 0; lives_m = 3; ptr_m = 0; frames_m = 0; play_m = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_hold", 32'(lane_hold), 32'hF);
        chk("rst_grab", 32'(lane_grab), 32'd0);
        chk("rst_busy", 32'(hook_busy), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_lives", 32'(lives), 32'd3);
        reset = 1'b0;
        cyc();
        chk("idle_state", 32'(state), 32'd0);

        // Game 1: staggered release
        start = 1'b1; cyc(); start = 1'b0; play_m = 1'b1; frames_m = 0;
        chk("play_state", 32'(state), 32'd1);
        chk("play_hold", 32'(lane_hold), 32'hF);
        for (int f = 1; f <= 125; f++) begin
            do_frame();
            chk("spawn_hold", 32'(lane_hold), 32'(hold_model(frames_m)));
        end

        // Hook arbitration and cooldown
        fire_and_check(4'b0101, hold_model(frames_m));
        cooldown(1'b1);
        fire_and_check(4'b0101, hold_model(frames_m));
        cooldown(1'b0);
        fire_and_check(4'b0000, hold_model(frames_m));
        chk("miss_score", 32'(score), 32'(score_m));
        cooldown(1'b0);
        repeat (5) begin
            fire_and_check(4'($urandom_range(0, 15)), hold_model(frames_m));
            cooldown(1'b0);
        end

        // Scoring up to saturation
        repeat (3) catch_lanes(4'b0100);
        while (score_m < 998) begin
            m = 4'($urandom_range(1, 15));
            if (score_m + $countones(m) > 998) m = 4'b0001;
            catch_lanes(m);
        end
        catch_lanes(4'b1111);
        catch_lanes(4'b0010);

        // Lives and game over
        fire_and_check(4'b0000, hold_model(frames_m));
        lane_dead = 4'b1010; cyc(); lives_m = 1;
        chk("lives_two_deaths", 32'(lives), 32'(lives_m));
        lane_dead = 4'b1011; cyc(); lives_m = 0;
        chk("lives_zero", 32'(lives), 32'd0);
        chk("still_play", 32'(state), 32'd1);
        cyc(); play_m = 1'b0;
        chk("over_state", 32'(state), 32'd2);
        chk("over_hold", 32'(lane_hold), 32'hF);
        chk("over_busy", 32'(hook_busy), 32'd0);
        catch_lanes(4'b0100);
        hook_req = 4'hF; hook_fire = 1'b1; cyc(); hook_fire = 1'b0;
        chk("over_grab", 32'(lane_grab), 32'd0);
        lane_dead = '0; cyc();
        chk("over_lives", 32'(lives), 32'd0);

        // Game 2
        start = 1'b1; cyc(); start = 1'b0;
        play_m = 1'b1; score_m = 0; lives_m = 3; frames_m = 0;
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_lives", 32'(lives), 32'd3);
        chk("restart_score", 32'(score), 32'd0);
        do_frame();
        chk("restart_hold", 32'(lane_hold), 32'(hold_model(frames_m)));
        fire_and_check(4'b1110, hold_model(frames_m));
        cooldown(1'b0);
        // catch on lane 1, death on lane 0 and a grab of lane 0, all in one clk
        lane_score = 4'b0011; cyc();
        lane_score = 4'b0000; lane_dead = 4'b0001; hook_req = 4'b0001; hook_fire = 1'b1;
        cyc();
        hook_fire = 1'b0;
        score_m = 1; lives_m = 2; ptr_m = 1;
        chk("combo_score", 32'(score), 32'(score_m));
        chk("combo_lives", 32'(lives), 32'(lives_m));
        chk("combo_grab", 32'(lane_grab), 32'b0001);
        cyc();
        chk("combo_grab_end", 32'(lane_grab), 32'd0);
        catch_lanes(4'b1111);
        chk("pre_reset_busy", 32'(hook_busy), 32'd1);

        // Asynchronous reset mid-cooldown
        @(posedge clk);
        #3;
        reset = 1'b1;
        hook_req = 4'hF; hook_fire = 1'b1;
        #1;
        chk("areset_state", 32'(state), 32'd0);
        chk("areset_hold", 32'(lane_hold), 32'hF);
        chk("areset_grab", 32'(lane_grab), 32'd0);
        chk("areset_busy", 32'(hook_busy), 32'd0);
        chk("areset_score", 32'(score), 32'd0);
        chk("areset_lives", 32'(lives), 32'd3);
        cyc();
        chk("areset_grab_hold", 32'(lane_grab), 32'd0);
        hook_fire = 1'b0; lane_dead = '0; reset = 1'b0;
        score_m = 0; lives_m = 3; ptr_m = 0; play_m = 1'b0;
        cyc();

        // Game 3: arbiter pointer must restart at lane 0
        start = 1'b1; cyc(); start = 1'b0; play_m = 1'b1; frames_m = 0;
        repeat (41) do_frame();
        chk("g3_hold", 32'(lane_hold), 32'(hold_model(frames_m)));
        fire_and_check(4'b0011, hold_model(frames_m));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
